// File: rtl/mix_out_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mix_out_pkg
// Description : Shared constants, gain FSM state type and saturation helper
//               for the mixer output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mix_out_pkg;

    localparam logic [15:0] UNITY_GAIN = 16'h8000;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } gain_state_t;

    // Clamp a signed value into the range of a signed word of 'width' bits.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] value,
        input int                 width
    );
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v)
            sat_signed = max_v;
        else if (value < min_v)
            sat_signed = min_v;
        else
            sat_signed = value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mix_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mix_out_fifo
// Description : Synchronous first-word-fall-through FIFO; DEPTH power of 2.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_out_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [AW-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [AW-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [AW:0]      r_count_q,  w_count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (push)
            w_wr_ptr_d = r_wr_ptr_q + AW'(1);
        if (pop)
            w_rd_ptr_d = r_rd_ptr_q + AW'(1);
        if (push && !pop)
            w_count_d = r_count_q + (AW+1)'(1);
        else if (pop && !push)
            w_count_d = r_count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            r_mem_q[r_wr_ptr_q] <= din;
    end

    assign dout  = r_mem_q[r_rd_ptr_q];
    assign full  = (r_count_q == (AW+1)'(DEPTH));
    assign empty = (r_count_q == '0);
    assign level = r_count_q;

endmodule
`default_nettype wire

// File: rtl/mix_output_stage.sv
`default_nettype none
// ============================================================================
// Module      : mix_output_stage
// Description : Ramped master gain, saturation to DAC width and output FIFO.
//               Optional clip counter enabled by MIX_OUT_CLIP_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_output_stage
    import mix_out_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 24,
    parameter int GAIN_WIDTH = 16,
    parameter int RAMP_STEP  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_WIDTH-1:0]           sample_in,
    input  logic                          sample_in_valid,
    input  logic [GAIN_WIDTH-1:0]         gain_target,
    input  logic                          gain_load,
    output logic [GAIN_WIDTH-1:0]         gain_current,
    output logic                          ramping,
    output logic [OUT_WIDTH-1:0]          sample_out,
    output logic                          sample_out_valid,
    input  logic                          sample_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          clip
`ifdef MIX_OUT_CLIP_COUNT_EN
   ,output logic [15:0]                   clip_count,
    input  logic                          clip_count_clr
`endif
);

    localparam int                    PROD_W = IN_WIDTH + GAIN_WIDTH + 1;
    localparam int                    SHIFT  = 15 + IN_WIDTH - OUT_WIDTH;
    localparam logic [GAIN_WIDTH-1:0] C_STEP = GAIN_WIDTH'(RAMP_STEP);

    gain_state_t              r_state_q,  w_state_d;
    logic [GAIN_WIDTH-1:0]    r_gain_q,   w_gain_d;
    logic [GAIN_WIDTH-1:0]    r_target_q, w_target_d;
    logic [GAIN_WIDTH-1:0]    w_diff;

    logic                     r_s1_vld_q, w_s1_vld_d;
    logic signed [PROD_W-1:0] r_prod_q,   w_prod_d;
    logic                     r_s2_vld_q, w_s2_vld_d;
    logic [OUT_WIDTH-1:0]     r_s2_data_q, w_s2_data_d;
    logic                     r_clip_q,   w_clip_d;
    logic                     r_overflow_q, w_overflow_d;

    logic signed [PROD_W-1:0] w_shift;
    logic signed [63:0]       w_ext;
    logic signed [63:0]       w_sat;

    logic                     w_push, w_pop, w_drop;
    logic                     w_full, w_empty;
    logic [OUT_WIDTH-1:0]     w_dout;

    // Gain FSM. In HOLD target equals gain, so the direction compare only
    // leaves HOLD on a load; a load while ramping re-aims the same cycle.
    always_comb begin
        w_target_d = gain_load ? gain_target : r_target_q;
        w_gain_d   = r_gain_q;
        w_diff     = (w_target_d > r_gain_q) ? (w_target_d - r_gain_q)
                                             : (r_gain_q - w_target_d);
        if (w_target_d > r_gain_q)
            w_state_d = RAMP_UP;
        else if (w_target_d < r_gain_q)
            w_state_d = RAMP_DOWN;
        else
            w_state_d = HOLD;
        if (r_state_q != HOLD && sample_in_valid) begin
            if (w_diff <= C_STEP) begin
                w_gain_d  = w_target_d;
                w_state_d = HOLD;
            end else if (w_target_d > r_gain_q) begin
                w_gain_d = r_gain_q + C_STEP;
            end else begin
                w_gain_d = r_gain_q - C_STEP;
            end
        end
    end

    // Two-stage datapath: multiply with the pre-step gain, then shift/saturate.
    always_comb begin
        w_s1_vld_d  = sample_in_valid;
        w_prod_d    = {{(PROD_W-IN_WIDTH){sample_in[IN_WIDTH-1]}}, sample_in}
                    * {{(PROD_W-GAIN_WIDTH){1'b0}}, r_gain_q};
        w_shift     = r_prod_q >>> SHIFT;
        w_ext       = {{(64-PROD_W){w_shift[PROD_W-1]}}, w_shift};
        w_sat       = sat_signed(w_ext, OUT_WIDTH);
        w_s2_vld_d  = r_s1_vld_q;
        w_s2_data_d = w_sat[OUT_WIDTH-1:0];
        w_clip_d    = r_s1_vld_q && (w_sat != w_ext);
    end

    always_comb begin
        w_pop        = !w_empty && sample_out_ready;
        w_push       = r_s2_vld_q && (!w_full || w_pop);
        w_drop       = r_s2_vld_q && w_full && !w_pop;
        w_overflow_d = r_overflow_q;
        if (w_drop)
            w_overflow_d = 1'b1;
        else if (overflow_clr)
            w_overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= HOLD;
            r_gain_q     <= GAIN_WIDTH'(UNITY_GAIN);
            r_target_q   <= GAIN_WIDTH'(UNITY_GAIN);
            r_s1_vld_q   <= 1'b0;
            r_prod_q     <= '0;
            r_s2_vld_q   <= 1'b0;
            r_s2_data_q  <= '0;
            r_clip_q     <= 1'b0;
            r_overflow_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_gain_q     <= w_gain_d;
            r_target_q   <= w_target_d;
            r_s1_vld_q   <= w_s1_vld_d;
            r_prod_q     <= w_prod_d;
            r_s2_vld_q   <= w_s2_vld_d;
            r_s2_data_q  <= w_s2_data_d;
            r_clip_q     <= w_clip_d;
            r_overflow_q <= w_overflow_d;
        end
    end

    mix_out_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_s2_data_q),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

`ifdef MIX_OUT_CLIP_COUNT_EN
    logic [15:0] r_clip_count_q, w_clip_count_d;

    always_comb begin
        w_clip_count_d = r_clip_count_q;
        if (clip_count_clr)
            w_clip_count_d = '0;
        else if (r_clip_q && r_clip_count_q != 16'hFFFF)
            w_clip_count_d = r_clip_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_clip_count_q <= '0;
        else
            r_clip_count_q <= w_clip_count_d;
    end

    assign clip_count = r_clip_count_q;
`endif

    assign gain_current     = r_gain_q;
    assign ramping          = (r_state_q != HOLD);
    assign sample_out_valid = !w_empty;
    assign sample_out       = w_empty ? '0 : w_dout;
    assign overflow         = r_overflow_q;
    assign clip             = r_clip_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_output_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mix_output_stage
// Description : Directed self-checking bench for mix_output_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mix_output_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sample_in;
    logic        sample_in_valid;
    logic [15:0] gain_target;
    logic        gain_load;
    logic [15:0] gain_current;
    logic        ramping;
    logic [23:0] sample_out;
    logic        sample_out_valid;
    logic        sample_out_ready;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        overflow_clr;
    logic        clip;
`ifdef MIX_OUT_CLIP_COUNT_EN
    logic [15:0] clip_count;
    logic        clip_count_clr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mix_output_stage dut (
        .clk              (clk),
        .rst              (rst),
        .sample_in        (sample_in),
        .sample_in_valid  (sample_in_valid),
        .gain_target      (gain_target),
        .gain_load        (gain_load),
        .gain_current     (gain_current),
        .ramping          (ramping),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .sample_out_ready (sample_out_ready),
        .fifo_level       (fifo_level),
        .overflow         (overflow),
        .overflow_clr     (overflow_clr),
        .clip             (clip)
`ifdef MIX_OUT_CLIP_COUNT_EN
       ,.clip_count       (clip_count),
        .clip_count_clr   (clip_count_clr)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All helpers start and end just after a falling edge.
    task automatic pulse_load(input logic [15:0] t);
        gain_target = t;
        gain_load   = 1'b1;
        @(negedge clk);
        gain_load   = 1'b0;
    endtask

    task automatic pulse_sample(input logic [31:0] d);
        sample_in       = d;
        sample_in_valid = 1'b1;
        @(negedge clk);
        sample_in_valid = 1'b0;
    endtask

    task automatic send_one(input string tag, input logic [31:0] d,
                            input logic [23:0] exp_out, input logic exp_clip);
        pulse_sample(d);
        chk({tag, "_lat1"}, sample_out_valid, 1'b0);
        @(negedge clk);
        chk({tag, "_clip"}, clip, exp_clip);
        chk({tag, "_lat2"}, sample_out_valid, 1'b0);
        @(negedge clk);
        chk({tag, "_valid"}, sample_out_valid, 1'b1);
        chk({tag, "_data"}, sample_out, exp_out);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst              = 1'b1;
        sample_in        = '0;
        sample_in_valid  = 1'b0;
        gain_target      = 16'h8000;
        gain_load        = 1'b0;
        sample_out_ready = 1'b1;
        overflow_clr     = 1'b0;
`ifdef MIX_OUT_CLIP_COUNT_EN
        clip_count_clr   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_gain", gain_current, 16'h8000);
        chk("rst_ramping", ramping, 1'b0);
        chk("rst_valid", sample_out_valid, 1'b0);
        chk("rst_data", sample_out, 24'h0);
        chk("rst_level", fifo_level, 4'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_clip", clip, 1'b0);

        // Unity gain passthrough
        send_one("unity", 32'h0001_2300, 24'h000123, 1'b0);
        send_one("unity_neg", 32'hFFFF_FF00, 24'hFFFFFF, 1'b0);

        // Ramp up in four samples, then retarget downward mid-ramp
        pulse_load(16'h8040);
        chk("ramp_start", ramping, 1'b1);
        chk("ramp_nostep", gain_current, 16'h8000);
        pulse_sample(32'h0);
        chk("ramp_1", gain_current, 16'h8010);
        pulse_sample(32'h0);
        chk("ramp_2", gain_current, 16'h8020);
        pulse_sample(32'h0);
        chk("ramp_3", gain_current, 16'h8030);
        chk("ramp_3_busy", ramping, 1'b1);
        pulse_sample(32'h0);
        chk("ramp_4", gain_current, 16'h8040);
        chk("ramp_hold", ramping, 1'b0);
        repeat (3) @(negedge clk);
        chk("ramp_idle", gain_current, 16'h8040);

        pulse_load(16'h8080);
        pulse_sample(32'h0);
        chk("retgt_up", gain_current, 16'h8050);
        pulse_load(16'h8000);
        chk("retgt_busy", ramping, 1'b1);
        pulse_sample(32'h0);
        chk("retgt_down", gain_current, 16'h8040);
        repeat (4) pulse_sample(32'h0);
        chk("retgt_end", gain_current, 16'h8000);
        chk("retgt_hold", ramping, 1'b0);

        // Load coincident with a step: the step aims at the new target
        pulse_load(16'h8100);
        pulse_sample(32'h0);
        chk("coinc_pre", gain_current, 16'h8010);
        gain_target     = 16'h8000;
        gain_load       = 1'b1;
        sample_in       = '0;
        sample_in_valid = 1'b1;
        @(negedge clk);
        gain_load       = 1'b0;
        sample_in_valid = 1'b0;
        chk("coinc_gain", gain_current, 16'h8000);
        chk("coinc_hold", ramping, 1'b0);
        repeat (4) @(negedge clk);

        // Backpressure: nine samples into eight entries
        sample_out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            sample_in       = 32'(i) << 8;
            sample_in_valid = 1'b1;
            @(negedge clk);
        end
        sample_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_level", fifo_level, 4'd8);
        chk("bp_overflow", overflow, 1'b1);
        sample_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("bp_drain_valid", sample_out_valid, 1'b1);
            chk("bp_drain_data", sample_out, 24'(i));
            @(negedge clk);
        end
        chk("bp_empty", sample_out_valid, 1'b0);
        chk("bp_level0", fifo_level, 4'd0);
        chk("bp_sticky", overflow, 1'b1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        chk("ovf_clr", overflow, 1'b0);

        // Full FIFO with push and pop in the same cycle
        sample_out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            sample_in       = 32'(i) << 8;
            sample_in_valid = 1'b1;
            @(negedge clk);
        end
        sample_in_valid = 1'b0;
        @(negedge clk);
        chk("fp_full", fifo_level, 4'd8);
        sample_out_ready = 1'b1;
        @(negedge clk);
        sample_out_ready = 1'b0;
        chk("fp_level", fifo_level, 4'd8);
        chk("fp_overflow", overflow, 1'b0);
        chk("fp_head", sample_out, 24'h000002);
        sample_out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("fp_drained", fifo_level, 4'd0);

        // Ramp to maximum gain and drive both saturation rails
        pulse_load(16'hFFFF);
        sample_in       = '0;
        sample_in_valid = 1'b1;
        n = 0;
        while (ramping && n < 5000) begin
            @(negedge clk);
            n++;
        end
        sample_in_valid = 1'b0;
        chk("max_ramp_done", ramping, 1'b0);
        chk("max_gain", gain_current, 16'hFFFF);
        repeat (4) @(negedge clk);
        send_one("clip_pos", 32'h7FFF_FFFF, 24'h7FFFFF, 1'b1);
        send_one("clip_neg", 32'h8000_0000, 24'h800000, 1'b1);
        send_one("gain2", 32'h0000_0800, 24'h00000F, 1'b0);
`ifdef MIX_OUT_CLIP_COUNT_EN
        chk("clip_count", clip_count, 16'd2);
`endif

        // Reset with samples in both pipeline stages and three queued
        sample_out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            sample_in       = 32'(i) << 8;
            sample_in_valid = 1'b1;
            @(negedge clk);
        end
        sample_in_valid = 1'b0;
        chk("mid_level", fifo_level, 4'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_valid", sample_out_valid, 1'b0);
        chk("mid_level0", fifo_level, 4'd0);
        chk("mid_gain", gain_current, 16'h8000);
        chk("mid_ramping", ramping, 1'b0);
        @(negedge clk);
        chk("mid_valid2", sample_out_valid, 1'b0);
        chk("mid_level2", fifo_level, 4'd0);
        @(negedge clk);
        chk("mid_valid3", sample_out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
